// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, bus widths, alignment.
package dmem_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int DMEM_AW = 9;
   localparam int DMEM_DW = 32;

   localparam logic [1:0] ALIGN_MASK = 2'b00;

   function automatic logic is_aligned(input logic [DMEM_AW-1:0] addr);
      return addr[1:0] == ALIGN_MASK;
   endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the port that did not win last time takes a tie.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic sel
);
   always_comb begin
      valid = req0 | req1;
      sel   = (req0 & req1) ? ~last : req1;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 128x32 data memory.
//
// state  | meaning
// IDLE   | waiting for a request; grant and payload latch happen here
// ACCESS | memory strobes held for ACCESS_CYCLES cycles
// RESP   | one-cycle rvalid/rdata/err pulse to the granted port
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ACCESS_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0,
   input  logic               req1,
   input  logic               we0,
   input  logic               we1,
   input  logic [DMEM_AW-1:0] addr0,
   input  logic [DMEM_AW-1:0] addr1,
   input  logic [DMEM_DW-1:0] wdata0,
   input  logic [DMEM_DW-1:0] wdata1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               rvalid0,
   output logic               rvalid1,
   output logic [DMEM_DW-1:0] rdata0,
   output logic [DMEM_DW-1:0] rdata1,
   output logic               err0,
   output logic               err1,
   output logic               mem_read,
   output logic               mem_write,
   output logic [DMEM_AW-1:0] mem_addr,
   output logic [DMEM_DW-1:0] mem_wdata,
   input  logic [DMEM_DW-1:0] mem_rdata
);
   logic [1:0]         state_q;
   logic [CNT_W-1:0]   count_q;
   logic               sel_q;
   logic               we_q;
   logic [DMEM_AW-1:0] addr_q;
   logic [DMEM_DW-1:0] wdata_q;
   logic [DMEM_DW-1:0] rdata_q;
   logic               err_q;
   logic               last_q;

   logic               pick_valid;
   logic               pick_sel;
   logic               win;
   logic               pay_we;
   logic [DMEM_AW-1:0] pay_addr;
   logic [DMEM_DW-1:0] pay_wdata;
   logic               last_cnt;
   logic [DMEM_DW-1:0] rdata_resp;

   rr_arb2 u_rr_arb2 (
      .req0  (req0),
      .req1  (req1),
      .last  (last_q),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   // Grant is gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      win        = rst_n && (state_q == ST_IDLE) && pick_valid;
      gnt0       = win & ~pick_sel;
      gnt1       = win & pick_sel;
      pay_we     = pick_sel ? we1 : we0;
      pay_addr   = pick_sel ? addr1 : addr0;
      pay_wdata  = pick_sel ? wdata1 : wdata0;
      last_cnt   = count_q == CNT_W'(ACCESS_CYCLES - 1);
      rdata_resp = (we_q | err_q) ? '0 : rdata_q;
      rvalid0    = (state_q == ST_RESP) & ~sel_q;
      rvalid1    = (state_q == ST_RESP) & sel_q;
      rdata0     = rvalid0 ? rdata_resp : '0;
      rdata1     = rvalid1 ? rdata_resp : '0;
      err0       = rvalid0 & err_q;
      err1       = rvalid1 & err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         sel_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         last_q    <= 1'b1;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (win) begin
                  sel_q   <= pick_sel;
                  we_q    <= pay_we;
                  addr_q  <= pay_addr;
                  wdata_q <= pay_wdata;
                  last_q  <= pick_sel;
                  if (!is_aligned(pay_addr)) begin
                     err_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end else begin
                     count_q   <= '0;
                     state_q   <= ST_ACCESS;
                     mem_read  <= ~pay_we;
                     mem_write <= pay_we;
                     mem_addr  <= pay_addr;
                     mem_wdata <= pay_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (last_cnt) begin
                  if (!we_q) rdata_q <= mem_rdata;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state_q   <= ST_RESP;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            ST_RESP: begin
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 128x32 word-addressed data memory (byte address [8:0], word index addr[8:2], combinational read gated by mem_read, write while mem_write is high).
- Shares the memory between port 0 (core load/store unit) and port 1 (loader/DMA).
- Round-robin arbitration, fixed-length memory access window, one-cycle response pulse per request.
- Sits between the requesters and the data memory; it is the only driver of the memory strobes.

Parameters:
- ACCESS_CYCLES, 1, cycles the memory strobe and address are held per access; legal range 1..15.
- CNT_W, 4, width of the access counter; must satisfy 2^CNT_W > ACCESS_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  port request; hold high with stable payload until gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  9  byte address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  one-cycle grant; payload is latched on this cycle.
- rvalid0 / rvalid1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data; valid while rvalid is high, 0 for writes and errors.
- err0 / err1  out  1  misaligned-address flag; valid while rvalid is high.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_addr  out  9  to data memory addr.
- mem_wdata  out  32  to data memory write_data.
- mem_rdata  in  32  from data memory read_data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including both mem strobes, so they drop immediately even mid-access.
  - Latched payload registers and rdata are 0.
  - Round-robin pointer last=1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Winner selection:
    - Only one req high → that port wins.
    - Both high → the port != last wins.
  - On the win, pulse gnt_w for that cycle and latch sel, we, addr, wdata. Set last=sel.
  - If latched addr[1:0] != 0: err_pending=1, next state RESP. No memory strobe is issued.
  - Otherwise: count=0, next state ACCESS.
  - No req → stay in IDLE, all strobes 0.
- ACCESS:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_read = !we.
  - mem_write = we.
  - All four are registered outputs, stable for exactly ACCESS_CYCLES cycles.
  - On the cycle count == ACCESS_CYCLES-1:
    - For a read, capture mem_rdata into the rdata register.
    - Next state RESP.
  - Otherwise count increments.
- RESP:
  - Strobes are 0.
  - rvalid_sel=1 for exactly one cycle.
  - rdata_sel = captured data for a read, 0 for a write or error.
  - err_sel = err_pending.
  - Next state IDLE. err_pending is cleared.
- Outputs on the non-selected port stay 0 throughout.
- Latency: grant to rvalid is ACCESS_CYCLES+1 cycles; error responses take 1 cycle.
- Throughput: one access per ACCESS_CYCLES+2 cycles. No grant is issued in ACCESS or RESP.
- Requests arriving in ACCESS or RESP wait. The req held high by the losing port is served next; strict alternation under continuous contention means no starvation.
- A port may drop req before gnt (withdrawal) with no side effect.
- req and payload changes after gnt are ignored until the next grant.
- mem_addr and mem_wdata hold their last value when idle. Only the strobes are guaranteed 0 outside ACCESS.
- rst_n asserted mid-ACCESS: no rvalid is produced for the aborted request; the memory write may be partial.

Decomposition:
- Shared package dmem_pkg:
  - State encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - DMEM_AW=9, DMEM_DW=32.
  - Alignment mask 2'b00.
- Natural sub-module rr_arb2:
  - Combinational 2-way round-robin pick from req0, req1, last.
  - Outputs: valid, sel.
  - Reused for future shared resources.
- FSM, counter and payload latch live in dmem_arbiter.

Test Plan:
- Single write then read, ACCESS_CYCLES=1:
  - Port 0 writes addr=0x010, wdata=0xDEADBEEF → gnt0 at cycle 0; mem_write=1 with mem_addr=0x010 for 1 cycle; rvalid0 at cycle 2 with rdata0=0.
  - Port 0 then reads addr=0x010 → rvalid0 with rdata0=0xDEADBEEF.
- Contention: req0 and req1 held high continuously from reset → grants in order gnt0, gnt1, gnt0, gnt1, spaced 3 cycles apart.
- Misaligned: port 1 reads addr=0x013 → gnt1, next cycle rvalid1=1, err1=1, rdata1=0, mem_read and mem_write never asserted.
- ACCESS_CYCLES=3: port 1 reads addr=0x1FC (word 127) preloaded with 0x12345678 → mem_read high exactly 3 cycles, rvalid1 4 cycles after gnt1, rdata1=0x12345678.
- Reset mid-access: port 0 write with ACCESS_CYCLES=3, rst_n=0 on the 2nd ACCESS cycle → mem_write falls asynchronously, no rvalid0. After release, a single req1 is granted first within one cycle of the pointer check (last=1 → port 0 preferred only on contention).
- Withdrawal: req1 is raised during port 0's ACCESS then dropped before RESP → no gnt1. The FSM returns to IDLE and stays there.
